// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, bit-period scaling and
// the width of the bit-period counter.
package uart_pkg;

  localparam int unsigned CNT_W         = 19;
  localparam int unsigned PRESCALE_MULT = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Bit period in clk_p cycles; a prescale of 0 behaves like 1.
  function automatic logic [CNT_W-1:0] bit_period(input logic [15:0] prescale);
    logic [15:0] ps;
    ps = (prescale == '0) ? 16'd1 : prescale;
    return CNT_W'(ps) * CNT_W'(PRESCALE_MULT);
  endfunction

endpackage

// File: rtl/uart_axis_transceiver_if.sv
// AXI-stream byte channel used for both the transmit and receive sides.
interface uart_axis_transceiver_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_bit_engine.sv
// UART transmit shift path: start bit, DATA_WIDTH data bits LSB first,
// stop bit, each held for one bit period sampled at frame start.
module uart_bit_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_p,
  input  logic                  reset,
  input  logic [15:0]           prescale,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tvalid,
  output logic                  tready,
  output logic                  txd,
  output logic                  busy
);

  tx_state_t             state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [CNT_W-1:0]      period, period_n;
  logic [3:0]            idx, idx_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  txd_q, txd_n;
  logic                  en_q;
  logic [CNT_W-1:0]      start_period;
  logic                  accept;

  assign start_period = bit_period(prescale);
  // en_q keeps tready low until the first clock after reset is released.
  assign tready = en_q & reset & (state == TX_IDLE);
  assign accept = tvalid & tready;
  assign txd    = txd_q;
  assign busy   = (state != TX_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk_p) begin
    if (!reset) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      period <= '0;
      idx    <= '0;
      sh     <= '0;
      txd_q  <= 1'b1;
      en_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      period <= period_n;
      idx    <= idx_n;
      sh     <= sh_n;
      txd_q  <= txd_n;
      en_q   <= 1'b1;
    end
  end

  // Next-state, bit timing and next line level.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period;
    idx_n    = idx;
    sh_n     = sh;
    txd_n    = txd_q;
    unique case (state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (accept) begin
          state_n  = TX_START;
          period_n = start_period;
          cnt_n    = start_period - CNT_W'(1);
          sh_n     = tdata;
          txd_n    = 1'b0;
        end
      end
      default: begin
        if (cnt == '0) begin
          cnt_n = period - CNT_W'(1);
          case (state)
            TX_START: begin
              state_n = TX_DATA;
              idx_n   = '0;
              txd_n   = sh[0];
              sh_n    = {1'b0, sh[DATA_WIDTH-1:1]};
            end
            TX_DATA: begin
              if (idx == 4'(DATA_WIDTH - 1)) begin
                state_n = TX_STOP;
                txd_n   = 1'b1;
              end else begin
                idx_n = idx + 4'd1;
                txd_n = sh[0];
                sh_n  = {1'b0, sh[DATA_WIDTH-1:1]};
              end
            end
            default: begin
              state_n = TX_IDLE;
              txd_n   = 1'b1;
            end
          endcase
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial input; resets to the
// line idle level so a reset never looks like a start bit.
module uart_sync (
  input  logic clk_p,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sr;

  // Shift the raw input through two flops.
  always_ff @(posedge clk_p) begin
    if (!reset) sr <= '1;
    else        sr <= {sr[0], d};
  end

  assign q = sr[1];

endmodule

// File: rtl/uart_axis_transceiver.sv
// UART transceiver: AXI-stream transmit and receive byte channels sharing a
// run-time baud prescaler. Optional feature macro UART_ERROR_FLAGS_EN adds
// the overrun_error and frame_error pulse outputs.
module uart_axis_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk_p,
  input  logic                    reset,
  input  logic [15:0]             prescale,
  uart_axis_transceiver_if.slave  s_axis,
  uart_axis_transceiver_if.master m_axis,
  output logic                    txd,
  input  logic                    rxd,
  output logic                    tx_busy,
  output logic                    rx_busy
`ifdef UART_ERROR_FLAGS_EN
  ,
  output logic                    overrun_error,
  output logic                    frame_error
`endif
);

  logic tx_ready;

  uart_bit_engine #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx (
    .clk_p    (clk_p),
    .reset    (reset),
    .prescale (prescale),
    .tdata    (s_axis.tdata),
    .tvalid   (s_axis.tvalid),
    .tready   (tx_ready),
    .txd      (txd),
    .busy     (tx_busy)
  );

  assign s_axis.tready = tx_ready;

  logic rx_s;

  uart_sync u_sync (
    .clk_p (clk_p),
    .reset (reset),
    .d     (rxd),
    .q     (rx_s)
  );

  rx_state_t             rx_state, rx_state_n;
  logic [CNT_W-1:0]      rcnt, rcnt_n;
  logic [CNT_W-1:0]      rper, rper_n;
  logic [3:0]            ridx, ridx_n;
  logic [DATA_WIDTH-1:0] rsh, rsh_n;
  logic [DATA_WIDTH-1:0] m_tdata_q, md_n;
  logic                  m_tvalid_q, mv_n;
  logic [CNT_W-1:0]      start_period;
  logic                  m_hs;
`ifdef UART_ERROR_FLAGS_EN
  logic                  ovr_q, ovr_n;
  logic                  ferr_q, ferr_n;
`endif

  assign start_period  = bit_period(prescale);
  assign m_hs          = m_tvalid_q & m_axis.tready;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign rx_busy       = (rx_state != RX_IDLE);
`ifdef UART_ERROR_FLAGS_EN
  assign overrun_error = ovr_q;
  assign frame_error   = ferr_q;
`endif

  // Receive state, sampling datapath and output channel registers.
  always_ff @(posedge clk_p) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rcnt       <= '0;
      rper       <= '0;
      ridx       <= '0;
      rsh        <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
`ifdef UART_ERROR_FLAGS_EN
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
`endif
    end else begin
      rx_state   <= rx_state_n;
      rcnt       <= rcnt_n;
      rper       <= rper_n;
      ridx       <= ridx_n;
      rsh        <= rsh_n;
      m_tdata_q  <= md_n;
      m_tvalid_q <= mv_n;
`ifdef UART_ERROR_FLAGS_EN
      ovr_q      <= ovr_n;
      ferr_q     <= ferr_n;
`endif
    end
  end

  // Receive next-state: start validation at half a bit, then centre sampling.
  always_comb begin
    rx_state_n = rx_state;
    rcnt_n     = rcnt;
    rper_n     = rper;
    ridx_n     = ridx;
    rsh_n      = rsh;
    md_n       = m_tdata_q;
    mv_n       = m_hs ? 1'b0 : m_tvalid_q;
`ifdef UART_ERROR_FLAGS_EN
    ovr_n      = 1'b0;
    ferr_n     = 1'b0;
`endif
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_n = RX_START;
          rper_n     = start_period;
          rcnt_n     = (start_period >> 1) - CNT_W'(1);
        end
      end
      RX_START: begin
        if (rcnt == '0) begin
          if (rx_s) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rcnt_n     = rper - CNT_W'(1);
            ridx_n     = '0;
          end
        end else begin
          rcnt_n = rcnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rcnt == '0) begin
          rsh_n  = {rx_s, rsh[DATA_WIDTH-1:1]};
          rcnt_n = rper - CNT_W'(1);
          if (ridx == 4'(DATA_WIDTH - 1)) rx_state_n = RX_STOP;
          else                            ridx_n     = ridx + 4'd1;
        end else begin
          rcnt_n = rcnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rcnt == '0) begin
          if (rx_s) begin
            md_n       = rsh;
            mv_n       = 1'b1;
            rx_state_n = RX_IDLE;
`ifdef UART_ERROR_FLAGS_EN
            ovr_n      = m_tvalid_q & ~m_hs;
`endif
          end else begin
            // A low stop bit may be a break; hold off until the line idles.
            rx_state_n = RX_WAIT_HIGH;
`ifdef UART_ERROR_FLAGS_EN
            ferr_n     = 1'b1;
`endif
          end
        end else begin
          rcnt_n = rcnt - CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_axis_transceiver.sv
// Self-checking bench for uart_axis_transceiver: randomized bytes and
// prescales checked against a frame-level model of the serial line.
module tb_uart_axis_transceiver;

  logic        clk_p = 1'b0;
  logic        reset;
  logic [15:0] prescale;
  logic        txd, rxd, rxd_drv, loop_en;
  logic        tx_busy, rx_busy;
`ifdef UART_ERROR_FLAGS_EN
  logic        overrun_error, frame_error;
  int          ovr_cnt = 0;
  int          ferr_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_got[$];
  int         vpulses = 0;
  logic       prev_tvalid = 1'b0;

  uart_axis_transceiver_if #(.DATA_WIDTH(8)) s_if ();
  uart_axis_transceiver_if #(.DATA_WIDTH(8)) m_if ();

  assign rxd = loop_en ? txd : rxd_drv;

  uart_axis_transceiver #(
    .DATA_WIDTH(8)
  ) dut (
    .clk_p         (clk_p),
    .reset         (reset),
    .prescale      (prescale),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .txd           (txd),
    .rxd           (rxd),
    .tx_busy       (tx_busy),
    .rx_busy       (rx_busy)
`ifdef UART_ERROR_FLAGS_EN
    ,
    .overrun_error (overrun_error),
    .frame_error   (frame_error)
`endif
  );

  always #5 clk_p = ~clk_p;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=done");
    $fatal(1, "watchdog");
  end

  // Observe the receive channel and error pulses between clock edges.
  always @(negedge clk_p) begin
    if (m_if.tvalid && m_if.tready) rx_got.push_back(m_if.tdata);
    if (m_if.tvalid && !prev_tvalid) vpulses++;
    prev_tvalid = m_if.tvalid;
`ifdef UART_ERROR_FLAGS_EN
    if (overrun_error) ovr_cnt++;
    if (frame_error)   ferr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pmodel(input int ps);
    return ((ps == 0) ? 1 : ps) * 8;
  endfunction

  // Line level of frame bit j: start 0, data LSB first, stop 1.
  function automatic logic fbit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    return 1'b1;
  endfunction

  task automatic wait_tready();
    int n;
    n = 0;
    while (!s_if.tready && n < 5000) begin
      @(negedge clk_p);
      n++;
    end
    if (n >= 5000) check("tready_timeout", {31'd0, s_if.tready}, 32'd1);
  endtask

  // Send one byte and check the whole txd waveform cycle by cycle.
  task automatic send_tx(input logic [7:0] d);
    int p;
    wait_tready();
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    @(posedge clk_p);
    #1 s_if.tvalid = 1'b0;
    if (loop_en) exp_q.push_back(d);
    p = pmodel(int'(prescale));
    for (int c = 0; c < 10 * p; c++) begin
      @(negedge clk_p);
      check($sformatf("txd_c%0d", c), {31'd0, txd}, {31'd0, fbit(d, c / p)});
      if (c == 0) begin
        check("tx_busy_frame", {31'd0, tx_busy}, 32'd1);
        check("tready_frame", {31'd0, s_if.tready}, 32'd0);
      end
    end
    @(negedge clk_p);
    check("tready_back", {31'd0, s_if.tready}, 32'd1);
    check("tx_busy_end", {31'd0, tx_busy}, 32'd0);
  endtask

  // Bit-bang a frame onto rxd; leaves the stop level on the line.
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    int p;
    p = pmodel(int'(prescale));
    for (int j = 0; j < 10; j++) begin
      rxd_drv = (j == 9) ? stop : fbit(d, j);
      repeat (p) @(negedge clk_p);
    end
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, rx_got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_got[i]}, {24'd0, exp_q[i]});
    exp_q.delete();
    rx_got.delete();
  endtask

  initial begin
    int base;
    int busy_cycles;
    logic [7:0] d;

    reset       = 1'b0;
    prescale    = 16'd1;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    rxd_drv     = 1'b1;
    loop_en     = 1'b0;

    // Reset values
    repeat (100) @(negedge clk_p);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_tready", {31'd0, s_if.tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("rst_m_tdata", {24'd0, m_if.tdata}, 32'd0);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b1;
    #1 check("tready_before_edge", {31'd0, s_if.tready}, 32'd0);
    @(negedge clk_p);
    check("tready_after_release", {31'd0, s_if.tready}, 32'd1);

    // Fixed pattern 0x55 at P=8
    send_tx(8'h55);

    // Loopback: console bytes then random bytes with random prescale
    loop_en = 1'b1;
    base = vpulses;
    send_tx(8'h14);
    send_tx(8'h73);
    for (int i = 0; i < 4; i++) begin
      prescale = 16'($urandom_range(0, 2));
      send_tx(8'($urandom));
    end
    prescale = 16'd1;
    repeat (20) @(negedge clk_p);
    check("loop_pulses", vpulses - base, exp_q.size());
    compare_rx("loop");
    loop_en = 1'b0;

    // Overrun: consumer stalled across two frames
    @(posedge clk_p);
    #1 m_if.tready = 1'b0;
    base = vpulses;
`ifdef UART_ERROR_FLAGS_EN
    ovr_cnt = 0;
`endif
    @(negedge clk_p);
    drive_frame(8'h41, 1'b1);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk_p);
    drive_frame(8'h42, 1'b1);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk_p);
    check("ovr_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    check("ovr_tdata", {24'd0, m_if.tdata}, 32'h42);
    check("ovr_one_pulse", vpulses - base, 32'd1);
`ifdef UART_ERROR_FLAGS_EN
    check("ovr_flag", ovr_cnt, 32'd1);
`endif
    @(posedge clk_p);
    #1 m_if.tready = 1'b1;
    repeat (3) @(negedge clk_p);
    check("ovr_tvalid_clear", {31'd0, m_if.tvalid}, 32'd0);
    exp_q.push_back(8'h42);
    compare_rx("ovr");

    // Frame error followed by a break, then a good frame
`ifdef UART_ERROR_FLAGS_EN
    ferr_cnt = 0;
`endif
    base = vpulses;
    drive_frame(8'($urandom), 1'b0);
    repeat (24) @(negedge clk_p);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk_p);
    check("ferr_no_tvalid", vpulses - base, 32'd0);
    check("ferr_rx_busy", {31'd0, rx_busy}, 32'd0);
`ifdef UART_ERROR_FLAGS_EN
    check("ferr_flag", ferr_cnt, 32'd1);
`endif
    compare_rx("ferr_drop");
    drive_frame(8'hA5, 1'b1);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk_p);
    exp_q.push_back(8'hA5);
    compare_rx("after_ferr");

    // 3-cycle glitch at prescale=4: start rejected after half a bit
    prescale = 16'd4;
    base = vpulses;
    busy_cycles = 0;
    rxd_drv = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_p);
      if (c == 2) rxd_drv = 1'b1;
      if (rx_busy) busy_cycles++;
    end
    check("glitch_busy_cycles", busy_cycles, pmodel(4) / 2);
    check("glitch_no_tvalid", vpulses - base, 32'd0);
    check("glitch_rx_busy", {31'd0, rx_busy}, 32'd0);
    prescale = 16'd1;

    // Reset mid-frame in loopback: TX aborts, partial RX is dropped
    loop_en = 1'b1;
    d = 8'($urandom) & 8'hFD;
    wait_tready();
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    @(posedge clk_p);
    #1 s_if.tvalid = 1'b0;
    repeat (20) @(negedge clk_p);
    check("mid_txd", {31'd0, txd}, {31'd0, fbit(d, 2)});
    reset = 1'b0;
    @(negedge clk_p);
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_tready", {31'd0, s_if.tready}, 32'd0);
    check("abort_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_rx_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk_p);
    check("abort_tready_back", {31'd0, s_if.tready}, 32'd1);
    repeat (100) @(negedge clk_p);
    compare_rx("abort_drop");

    // Recovery after abort
    send_tx(8'($urandom));
    repeat (20) @(negedge clk_p);
    compare_rx("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
